// File: rtl/vocab_mem_arbiter.sv
// Round-robin arbiter sharing one vocabulary-memory read port among NUM_REQ tokenizers.
// Accepted reads are tagged in an in-order FIFO so returning data reaches its issuer.
module vocab_mem_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 512,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_REQ-1:0]                  req_rd_en_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]       req_rd_addr_i,
    output logic [NUM_REQ-1:0]                  req_rd_ready_o,
    output logic [NUM_REQ-1:0]                  rsp_rd_valid_o,
    output logic [DATA_WIDTH-1:0]               rsp_rd_data_o,
    output logic                                mem_rd_en_o,
    output logic [ADDR_WIDTH-1:0]               mem_rd_addr_o,
    input  logic                                mem_rd_ready_i,
    input  logic [DATA_WIDTH-1:0]               mem_rd_data_i,
    input  logic                                mem_rd_valid_i,
    output logic [$clog2(MAX_OUTSTANDING):0]    outstanding_o,
    output logic                                err_spurious_o
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [OW-1:0] MAX_OUT   = OW'(MAX_OUTSTANDING);
    localparam logic [IW:0]   NREQ      = (IW+1)'(NUM_REQ);
    localparam logic [IW-1:0] LAST_REQ  = IW'(NUM_REQ - 1);

    logic                  mem_rd_en_q, mem_rd_en_d;
    logic [ADDR_WIDTH-1:0] mem_rd_addr_q, mem_rd_addr_d;
    logic [OW-1:0]         outstanding_q, outstanding_d;
    logic                  err_spurious_q, err_spurious_d;
    logic [IW-1:0]         last_grant_q, last_grant_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [IW-1:0]         tag_mem_q [MAX_OUTSTANDING];

    logic                  cmd_free_s;
    logic                  gnt_found_s;
    logic [IW-1:0]         gnt_idx_s;
    logic [IW:0]           cand_s;
    logic                  grant_s;
    logic                  pop_s;
    logic [IW-1:0]         head_s;

    // Round-robin search starting one past the last winner
    always_comb begin
        gnt_found_s = 1'b0;
        gnt_idx_s   = '0;
        cand_s      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_s = {1'b0, last_grant_q} + (IW+1)'(k + 1);
            if (cand_s >= NREQ) begin
                cand_s = cand_s - NREQ;
            end else begin
                cand_s = cand_s;
            end
            if (!gnt_found_s && req_rd_en_i[cand_s[IW-1:0]]) begin
                gnt_found_s = 1'b1;
                gnt_idx_s   = cand_s[IW-1:0];
            end else begin
                gnt_found_s = gnt_found_s;
            end
        end
    end

    assign cmd_free_s = !mem_rd_en_q || mem_rd_ready_i;
    // No bypass: a full FIFO blocks the grant even in a pop cycle.
    assign grant_s    = cmd_free_s && (outstanding_q < MAX_OUT) && gnt_found_s;
    assign pop_s      = mem_rd_valid_i && (outstanding_q != '0);
    assign head_s     = tag_mem_q[rd_ptr_q];

    // Grant and response strobes, plus next-state for the command/tag state
    always_comb begin
        req_rd_ready_o = '0;
        rsp_rd_valid_o = '0;
        mem_rd_en_d    = mem_rd_en_q;
        mem_rd_addr_d  = mem_rd_addr_q;
        last_grant_d   = last_grant_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        outstanding_d  = outstanding_q;
        err_spurious_d = err_spurious_q || (mem_rd_valid_i && (outstanding_q == '0));

        if (grant_s) begin
            req_rd_ready_o[gnt_idx_s] = 1'b1;
            mem_rd_en_d   = 1'b1;
            mem_rd_addr_d = req_rd_addr_i[int'(gnt_idx_s)*ADDR_WIDTH +: ADDR_WIDTH];
            last_grant_d  = gnt_idx_s;
            wr_ptr_d      = wr_ptr_q + PW'(1);
        end else if (cmd_free_s) begin
            mem_rd_en_d   = 1'b0;
        end else begin
            mem_rd_en_d   = mem_rd_en_q;
        end

        if (pop_s) begin
            rsp_rd_valid_o[head_s] = 1'b1;
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({grant_s, pop_s})
            2'b10:   outstanding_d = outstanding_q + OW'(1);
            2'b01:   outstanding_d = outstanding_q - OW'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_rd_en_q    <= 1'b0;
            mem_rd_addr_q  <= '0;
            outstanding_q  <= '0;
            err_spurious_q <= 1'b0;
            last_grant_q   <= LAST_REQ;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
        end else begin
            mem_rd_en_q    <= mem_rd_en_d;
            mem_rd_addr_q  <= mem_rd_addr_d;
            outstanding_q  <= outstanding_d;
            err_spurious_q <= err_spurious_d;
            last_grant_q   <= last_grant_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
        end
    end

    // Tag storage: requester ID of every accepted read, in issue order
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                tag_mem_q[i] <= '0;
            end
        end else if (grant_s) begin
            tag_mem_q[wr_ptr_q] <= gnt_idx_s;
        end
    end

    assign rsp_rd_data_o  = mem_rd_data_i;
    assign mem_rd_en_o    = mem_rd_en_q;
    assign mem_rd_addr_o  = mem_rd_addr_q;
    assign outstanding_o  = outstanding_q;
    assign err_spurious_o = err_spurious_q;

endmodule

// File: tb/tb_vocab_mem_arbiter.sv
// Directed self-checking bench for vocab_mem_arbiter (NUM_REQ=4, MAX_OUTSTANDING=8).
module tb_vocab_mem_arbiter;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [3:0]     req_rd_en;
    logic [127:0]   req_rd_addr;
    logic [3:0]     req_rd_ready;
    logic [3:0]     rsp_rd_valid;
    logic [511:0]   rsp_rd_data;
    logic           mem_rd_en;
    logic [31:0]    mem_rd_addr;
    logic           mem_rd_ready;
    logic [511:0]   mem_rd_data;
    logic           mem_rd_valid;
    logic [3:0]     outstanding;
    logic           err_spurious;

    int total = 0;
    int bad   = 0;

    logic [31:0] addr_tab [4];

    vocab_mem_arbiter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_rd_en_i    (req_rd_en),
        .req_rd_addr_i  (req_rd_addr),
        .req_rd_ready_o (req_rd_ready),
        .rsp_rd_valid_o (rsp_rd_valid),
        .rsp_rd_data_o  (rsp_rd_data),
        .mem_rd_en_o    (mem_rd_en),
        .mem_rd_addr_o  (mem_rd_addr),
        .mem_rd_ready_i (mem_rd_ready),
        .mem_rd_data_i  (mem_rd_data),
        .mem_rd_valid_i (mem_rd_valid),
        .outstanding_o  (outstanding),
        .err_spurious_o (err_spurious)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_rd_en    = 4'b0000;
        mem_rd_ready = 1'b1;
        mem_rd_valid = 1'b0;
        mem_rd_data  = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int exp_out;
        int c;
        addr_tab[0] = 32'h0000_0100;
        addr_tab[1] = 32'h0000_1000;
        addr_tab[2] = 32'h0000_2000;
        addr_tab[3] = 32'h0000_3000;
        req_rd_addr = {addr_tab[3], addr_tab[2], addr_tab[1], addr_tab[0]};
        rst_n = 1'b0;
        idle_inputs();
        #2;
        chk("rst_mem_en",   512'(mem_rd_en),    512'(1'b0));
        chk("rst_mem_addr", 512'(mem_rd_addr),  512'(32'h0));
        chk("rst_out",      512'(outstanding),  512'(4'd0));
        chk("rst_err",      512'(err_spurious), 512'(1'b0));
        chk("rst_ready",    512'(req_rd_ready), 512'(4'b0000));
        chk("rst_rsp",      512'(rsp_rd_valid), 512'(4'b0000));
        do_reset();

        // Single requester 2
        tick(); req_rd_en = 4'b0100; #1;
        chk("t1_c0_ready", 512'(req_rd_ready), 512'(4'b0100));
        chk("t1_c0_en",    512'(mem_rd_en),    512'(1'b0));
        tick(); req_rd_en = 4'b0000; #1;
        chk("t1_c1_en",    512'(mem_rd_en),    512'(1'b1));
        chk("t1_c1_addr",  512'(mem_rd_addr),  512'(32'h0000_2000));
        chk("t1_c1_out",   512'(outstanding),  512'(4'd1));
        tick(); #1;
        chk("t1_c2_en",    512'(mem_rd_en),    512'(1'b0));
        tick(); mem_rd_valid = 1'b1; mem_rd_data = {16{32'hCAFE_0002}}; #1;
        chk("t1_c3_rsp",   512'(rsp_rd_valid), 512'(4'b0100));
        chk("t1_c3_data",  rsp_rd_data,        {16{32'hCAFE_0002}});
        tick(); mem_rd_valid = 1'b0; #1;
        chk("t1_c4_out",   512'(outstanding),  512'(4'd0));
        chk("t1_c4_rsp",   512'(rsp_rd_valid), 512'(4'b0000));

        // All four requesting, responses two cycles behind the command
        do_reset();
        exp_out = 0;
        for (c = 0; c < 12; c++) begin
            tick();
            req_rd_en    = (c < 8) ? 4'b1111 : 4'b0000;
            mem_rd_valid = (c >= 3 && c < 11);
            mem_rd_data  = {16{32'hD000_0000 + 32'(c)}};
            #1;
            chk($sformatf("t2_c%0d_ready", c), 512'(req_rd_ready),
                512'((c < 8) ? (4'b0001 << (c % 4)) : 4'b0000));
            chk($sformatf("t2_c%0d_rsp", c), 512'(rsp_rd_valid),
                512'((c >= 3 && c < 11) ? (4'b0001 << ((c - 3) % 4)) : 4'b0000));
            chk($sformatf("t2_c%0d_out", c), 512'(outstanding), 512'(exp_out));
            chk($sformatf("t2_c%0d_en", c), 512'(mem_rd_en), 512'(c >= 1 && c <= 8));
            if (c >= 1 && c <= 8) begin
                chk($sformatf("t2_c%0d_addr", c), 512'(mem_rd_addr), 512'(addr_tab[(c - 1) % 4]));
            end
            exp_out = exp_out + ((c < 8) ? 1 : 0) - ((c >= 3 && c < 11) ? 1 : 0);
        end

        // Backpressure: command held while memory stalls
        do_reset();
        tick(); req_rd_en = 4'b0001; #1;
        chk("t3_c0_ready", 512'(req_rd_ready), 512'(4'b0001));
        for (c = 1; c <= 5; c++) begin
            tick(); req_rd_en = 4'b0010; mem_rd_ready = 1'b0; #1;
            chk($sformatf("t3_c%0d_ready", c), 512'(req_rd_ready), 512'(4'b0000));
            chk($sformatf("t3_c%0d_en", c),    512'(mem_rd_en),    512'(1'b1));
            chk($sformatf("t3_c%0d_addr", c),  512'(mem_rd_addr),  512'(32'h0000_0100));
        end
        tick(); mem_rd_ready = 1'b1; #1;
        chk("t3_c6_ready", 512'(req_rd_ready), 512'(4'b0010));
        chk("t3_c6_out",   512'(outstanding),  512'(4'd1));
        tick(); req_rd_en = 4'b0000; #1;
        chk("t3_c7_en",    512'(mem_rd_en),    512'(1'b1));
        chk("t3_c7_addr",  512'(mem_rd_addr),  512'(32'h0000_1000));
        chk("t3_c7_out",   512'(outstanding),  512'(4'd2));
        tick(); #1;
        chk("t3_c8_en",    512'(mem_rd_en),    512'(1'b0));

        // Outstanding limit with no bypass on the pop cycle
        do_reset();
        for (c = 0; c < 8; c++) begin
            tick(); req_rd_en = 4'b1111; #1;
            chk($sformatf("t4_c%0d_ready", c), 512'(req_rd_ready), 512'(4'b0001 << (c % 4)));
        end
        tick(); #1;
        chk("t4_c8_out",   512'(outstanding),  512'(4'd8));
        chk("t4_c8_ready", 512'(req_rd_ready), 512'(4'b0000));
        tick(); mem_rd_valid = 1'b1; mem_rd_data = {16{32'hBEEF_0000}}; #1;
        chk("t4_c9_ready", 512'(req_rd_ready), 512'(4'b0000));
        chk("t4_c9_rsp",   512'(rsp_rd_valid), 512'(4'b0001));
        chk("t4_c9_out",   512'(outstanding),  512'(4'd8));
        tick(); mem_rd_valid = 1'b0; #1;
        chk("t4_c10_out",   512'(outstanding),  512'(4'd7));
        chk("t4_c10_ready", 512'(req_rd_ready), 512'(4'b0001));
        tick(); req_rd_en = 4'b0000; #1;
        chk("t4_c11_out",   512'(outstanding),  512'(4'd8));
        chk("t4_c11_addr",  512'(mem_rd_addr),  512'(32'h0000_0100));

        // Simultaneous push and pop at outstanding=3
        do_reset();
        for (c = 0; c < 3; c++) begin
            tick(); req_rd_en = 4'b1111; #1;
        end
        tick(); mem_rd_valid = 1'b1; #1;
        chk("t5_c3_out",   512'(outstanding),  512'(4'd3));
        chk("t5_c3_ready", 512'(req_rd_ready), 512'(4'b1000));
        chk("t5_c3_rsp",   512'(rsp_rd_valid), 512'(4'b0001));
        tick(); req_rd_en = 4'b0000; mem_rd_valid = 1'b0; #1;
        chk("t5_c4_out",   512'(outstanding),  512'(4'd3));
        tick(); mem_rd_valid = 1'b1; #1;
        chk("t5_c5_rsp",   512'(rsp_rd_valid), 512'(4'b0010));

        // Spurious response, then reset in the middle of a burst
        do_reset();
        tick(); mem_rd_valid = 1'b1; #1;
        chk("t6_c0_rsp",  512'(rsp_rd_valid), 512'(4'b0000));
        tick(); mem_rd_valid = 1'b0; req_rd_en = 4'b1111; #1;
        chk("t6_c1_err",  512'(err_spurious), 512'(1'b1));
        chk("t6_c1_out",  512'(outstanding),  512'(4'd0));
        tick(); #1;
        chk("t6_c2_en",   512'(mem_rd_en),    512'(1'b1));
        tick(); #1;
        chk("t6_c3_out",  512'(outstanding),  512'(4'd2));
        #2;
        rst_n = 1'b0;
        req_rd_en = 4'b0000;
        #1;
        chk("t6_rst_en",    512'(mem_rd_en),    512'(1'b0));
        chk("t6_rst_addr",  512'(mem_rd_addr),  512'(32'h0));
        chk("t6_rst_out",   512'(outstanding),  512'(4'd0));
        chk("t6_rst_err",   512'(err_spurious), 512'(1'b0));
        chk("t6_rst_ready", 512'(req_rd_ready), 512'(4'b0000));
        tick();
        rst_n = 1'b1;
        tick(); mem_rd_valid = 1'b1; #1;
        chk("t6_late_rsp", 512'(rsp_rd_valid), 512'(4'b0000));
        tick(); mem_rd_valid = 1'b0; #1;
        chk("t6_late_err", 512'(err_spurious), 512'(1'b1));
        chk("t6_late_out", 512'(outstanding),  512'(4'd0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vocab_mem_arbiter.md
# vocab_mem_arbiter

Shares the single vocabulary-memory read port among NUM_REQ tokenizer instances. Arbitration is round-robin. Every accepted read is tagged with its requester ID in an in-order tag FIFO, and each returning data beat is routed back to the requester that issued it. The block sits between the tokenizers' mem_rd_* ports and the vocabulary memory controller. It bounds outstanding reads so responses are never lost.

## Interface
- NUM_REQ, 4: number of requesters (2..8)
- ADDR_WIDTH, 32: read address width
- DATA_WIDTH, 512: read data width, equal to the tokenizer bus width
- MAX_OUTSTANDING, 8: tag FIFO depth and in-flight read limit (power of 2)
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_rd_en  in  NUM_REQ  per-requester read request; level, held until accepted
- req_rd_addr  in  NUM_REQ×ADDR_WIDTH  per-requester read address
- req_rd_ready  out  NUM_REQ  one-hot grant; request accepted this cycle
- rsp_rd_valid  out  NUM_REQ  one-hot response strobe to the owning requester
- rsp_rd_data  out  DATA_WIDTH  response data, broadcast to all requesters
- mem_rd_en  out  1  read command valid to memory
- mem_rd_addr  out  ADDR_WIDTH  read command address
- mem_rd_ready  in  1  memory accepts command when mem_rd_en && mem_rd_ready
- mem_rd_data  in  DATA_WIDTH  memory read data, returned in order
- mem_rd_valid  in  1  memory read data valid
- outstanding  out  $clog2(MAX_OUTSTANDING)+1  reads granted whose response has not returned
- err_spurious  out  1  sticky flag: mem_rd_valid arrived while the tag FIFO was empty

## Operation
- Command register: mem_rd_en/mem_rd_addr. The register is "free" when !mem_rd_en || mem_rd_ready.
- Grant condition (combinational): register free && outstanding < MAX_OUTSTANDING && any req_rd_en.
- Round-robin: search starts at last_grant+1 mod NUM_REQ. The first requester with req_rd_en set wins. last_grant updates to the winner on grant.
- On grant to requester i:
  - req_rd_ready[i]=1 in the same cycle.
  - Next cycle, mem_rd_en=1 and mem_rd_addr=req_rd_addr[i].
  - Tag FIFO pushes i; outstanding increments.
- If the register is free and there is no grant, mem_rd_en clears next cycle.
- A command is held stable while mem_rd_en && !mem_rd_ready.
- Response routing (combinational, zero latency):
  - rsp_rd_data = mem_rd_data.
  - rsp_rd_valid[head]=mem_rd_valid, where head is the tag FIFO head.
  - The FIFO pops and outstanding decrements on mem_rd_valid.
- Push and pop in the same cycle: outstanding is unchanged, and the FIFO pointers both advance.
- No bypass: when outstanding==MAX_OUTSTANDING there is no grant, even if a pop occurs in the same cycle.
- mem_rd_valid with an empty FIFO: no rsp_rd_valid, no pop, outstanding stays 0, err_spurious=1 until reset.
- Requesters whose req_rd_en is deasserted before grant are simply skipped. There is no error for this.

## Timing
- Reset values:
  - mem_rd_en=0, mem_rd_addr=0.
  - outstanding=0, err_spurious=0.
  - FIFO empty.
  - last_grant=NUM_REQ-1, so requester 0 has first priority.
  - req_rd_ready and rsp_rd_valid are 0 because their inputs are gated by the reset state.
- Request-to-command latency: 1 cycle after the accept cycle.
- Sustained throughput: 1 grant/cycle while mem_rd_ready=1 and outstanding < MAX_OUTSTANDING.
- Fairness: with all NUM_REQ requesting continuously, each is granted exactly once per NUM_REQ grants.
- Response latency through the block: 0 cycles.
- Reset mid-operation: all state clears immediately and in-flight tags are discarded. Any memory response arriving after reset sets err_spurious.
- Pointer wrap: FIFO pointers wrap modulo MAX_OUTSTANDING. Full/empty are derived from outstanding.

## Test plan
- Single requester: req 2 reads 0x2000 with mem_rd_ready=1 and data returned 3 cycles later -> req_rd_ready[2] in cycle 0; mem_rd_en with addr 0x2000 in cycle 1; rsp_rd_valid=4'b0100 with matching data; outstanding goes 0→1→0.
- All 4 requesting continuously, mem always ready, responses lagging by 2 cycles -> grant order 0,1,2,3,0,1,...; each response routed to its issuer in issue order.
- Backpressure: mem_rd_ready=0 for 5 cycles with req 1 pending -> mem_rd_en/addr held stable and no further grants; the grant resumes the cycle mem_rd_ready=1.
- Limit: 8 reads issued with no responses -> outstanding=8 and req_rd_ready stays 0 even in the pop cycle; after one response, a grant occurs the following cycle.
- Simultaneous push/pop at outstanding=3 -> outstanding remains 3, and the routed tag is the oldest.
- Spurious response: mem_rd_valid with the FIFO empty -> no rsp_rd_valid, err_spurious=1. Then assert rst_n low mid-burst -> all outputs return to reset values.
